core_run_ctrl: RTL and testbench

//  Host-side run controller, directly upstream of the processor top level.

---
 rtl/run_ctrl_pkg.sv | 24 ++
 rtl/sat_counter.sv | 38 +++
 rtl/core_run_ctrl.sv | 129 ++++++++++++
 tb/tb_core_run_ctrl.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/run_ctrl_pkg.sv
// Shared types and default constants for the core run controller.
package run_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RESET = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } run_state_t;

    localparam int unsigned RST_CYCLES_DEF = 4;
    localparam int unsigned CW_DEF         = 16;
    localparam int unsigned MAX_CYCLES_DEF = 60000;

    // The core is held in reset while parked in IDLE and during the reset hold.
    function automatic logic holds_core_reset(input run_state_t s);
        return (s == IDLE) || (s == RESET);
    endfunction

    function automatic logic is_busy(input run_state_t s);
        return (s == RESET) || (s == RUN);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear and enable that sticks at its all-ones value.
module sat_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear_i,
    input  logic         en_i,
    output logic [W-1:0] count_o
);

    localparam logic [W-1:0] CNT_MAX = '1;

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // NOTE: every signal written here gets a default first, so no latch is inferred.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (en_i && (count_q != CNT_MAX)) begin
            count_d = count_q + 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/core_run_ctrl.sv
// Sequences one processor run: reset hold, start pulse, wait for done or watchdog,
// then presents sticky status to the host. All outputs are registered.
module core_run_ctrl
    import run_ctrl_pkg::*;
#(
    parameter int unsigned RST_CYCLES = RST_CYCLES_DEF,
    parameter int unsigned CW         = CW_DEF,
    parameter int unsigned MAX_CYCLES = MAX_CYCLES_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          core_done,
    output logic          core_reset,
    output logic          core_req,
    output logic          busy,
    output logic          done,
    output logic          timeout,
    output logic [CW-1:0] cycle_count
);

    localparam int unsigned   RW        = $clog2(RST_CYCLES + 1);
    localparam logic [RW-1:0] RST_LAST  = RW'(RST_CYCLES - 1);
    localparam logic [CW-1:0] CNT_LIMIT = CW'(MAX_CYCLES);

    run_state_t state_q, state_d;

    logic core_reset_q, core_reset_d;
    logic core_req_q,   core_req_d;
    logic busy_q,       busy_d;
    logic done_q,       done_d;
    logic timeout_q,    timeout_d;

    logic [RW-1:0] rst_cnt;
    logic [CW-1:0] run_cnt;
    logic          finish_ok;
    logic          finish_wd;
    logic          enter_reset;

    // Reset-hold counter: zero outside RESET, counts RESET cycles from 0.
    sat_counter #(.W(RW)) u_rst_cnt (
        .clk     (clk),
        .reset   (reset),
        .clear_i (state_q != RESET),
        .en_i    (state_q == RESET),
        .count_o (rst_cnt)
    );

    // Run-cycle counter: cleared on entry to RESET, bumped on every edge that lands in RUN,
    // so it reads 1 on the first RUN cycle and holds its value once DONE is entered.
    sat_counter #(.W(CW)) u_run_cnt (
        .clk     (clk),
        .reset   (reset),
        .clear_i (state_d == RESET),
        .en_i    (state_d == RUN),
        .count_o (run_cnt)
    );

    always_comb begin
        state_d   = state_q;
        done_d    = done_q;
        timeout_d = timeout_q;
        finish_ok = 1'b0;
        finish_wd = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) state_d = RESET;
            end
            RESET: begin
                if (rst_cnt == RST_LAST) state_d = RUN;
            end
            RUN: begin
                // Done seen on the request cycle is left over from the previous run.
                finish_ok = core_done && !core_req_q;
                finish_wd = (run_cnt == CNT_LIMIT);
                if (finish_ok || finish_wd) begin
                    state_d   = DONE;
                    done_d    = 1'b1;
                    timeout_d = !finish_ok;
                end
            end
            DONE: begin
                if (start) state_d = RESET;
            end
            default: state_d = IDLE;
        endcase

        enter_reset = (state_d == RESET) && (state_q != RESET);
        if (enter_reset) begin
            done_d    = 1'b0;
            timeout_d = 1'b0;
        end

        core_reset_d = holds_core_reset(state_d);
        busy_d       = is_busy(state_d);
        core_req_d   = (state_d == RUN) && (state_q != RUN);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            core_reset_q <= 1'b1;
            core_req_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            core_reset_q <= core_reset_d;
            core_req_q   <= core_req_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            timeout_q    <= timeout_d;
        end
    end

    assign core_reset  = core_reset_q;
    assign core_req    = core_req_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign timeout     = timeout_q;
    assign cycle_count = run_cnt;

    a_req_in_busy:   assert property (@(posedge clk) disable iff (reset) core_req_q |-> busy_q);
    a_done_not_busy: assert property (@(posedge clk) disable iff (reset) done_q |-> !busy_q);
    a_timeout_done:  assert property (@(posedge clk) disable iff (reset) timeout_q |-> done_q);

endmodule

// File: tb/tb_core_run_ctrl.sv
// Scoreboard bench for core_run_ctrl: stimulus queues expected run results, a monitor
// compares them whenever done rises.
module tb_core_run_ctrl;

    localparam int RST  = 4;
    localparam int CW   = 16;
    localparam int MAXC = 100;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          core_done;
    logic          core_reset;
    logic          core_req;
    logic          busy;
    logic          done;
    logic          timeout;
    logic [CW-1:0] cycle_count;

    always #5 clk = ~clk;

    core_run_ctrl #(
        .RST_CYCLES (RST),
        .CW         (CW),
        .MAX_CYCLES (MAXC)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .core_done   (core_done),
        .core_reset  (core_reset),
        .core_req    (core_req),
        .busy        (busy),
        .done        (done),
        .timeout     (timeout),
        .cycle_count (cycle_count)
    );

    typedef struct packed {
        logic          to;
        logic [CW-1:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   req_seen = 0;
    int   cur      = 0;
    int   n_rst    = 0;
    logic done_prev = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic exp_t mk_exp(input logic to, input int cnt);
        exp_t e;
        e.to  = to;
        e.cnt = CW'(cnt);
        return e;
    endfunction

    // cur tracks the run cycle index: RUN cycle 1 is cur==1, RESET cycles are cur<=0.
    task automatic advance_to(input int k);
        while (cur < k) begin
            @(posedge clk);
            #1;
            cur++;
        end
    endtask

    task automatic start_run();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        cur = 1 - RST;
    endtask

    // Monitor: counts request cycles and scores every run completion.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (core_req === 1'b1) req_seen++;
            if (done === 1'b1 && !done_prev) begin
                if (exp_q.size() == 0) begin
                    check("done_unexpected", {31'd0, done}, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("done_timeout", {31'd0, timeout}, {31'd0, e.to});
                    check("done_cycle_count", {16'd0, cycle_count}, {16'd0, e.cnt});
                    check("done_busy", {31'd0, busy}, 0);
                end
            end
            done_prev = (done === 1'b1);
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "bench time limit expired");
    end

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        core_done = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("rst_core_reset",  {31'd0, core_reset}, 1);
        check("rst_core_req",    {31'd0, core_req}, 0);
        check("rst_busy",        {31'd0, busy}, 0);
        check("rst_done",        {31'd0, done}, 0);
        check("rst_timeout",     {31'd0, timeout}, 0);
        check("rst_cycle_count", {16'd0, cycle_count}, 0);

        // Normal run; done held through RESET and the request cycle must be ignored,
        // as must a start pulse mid-run.
        exp_q.push_back(mk_exp(1'b0, 37));
        start_run();
        core_done = 1'b1;
        advance_to(1);
        @(negedge clk);
        check("req_cycle_core_req",    {31'd0, core_req}, 1);
        check("req_cycle_core_reset",  {31'd0, core_reset}, 0);
        check("req_cycle_count",       {16'd0, cycle_count}, 1);
        check("req_cycle_busy",        {31'd0, busy}, 1);
        advance_to(2);
        core_done = 1'b0;
        advance_to(10);
        start = 1'b1;
        advance_to(11);
        start = 1'b0;
        @(negedge clk);
        check("start_in_run_busy",  {31'd0, busy}, 1);
        check("start_in_run_count", {16'd0, cycle_count}, 11);
        check("start_in_run_req",   {31'd0, core_req}, 0);
        advance_to(37);
        core_done = 1'b1;
        advance_to(38);
        core_done = 1'b0;
        @(negedge clk);
        check("done_state_core_reset", {31'd0, core_reset}, 0);
        advance_to(39);
        @(negedge clk);
        check("req_pulses_run1", req_seen, 1);

        // Watchdog expiry with core_done never asserted.
        exp_q.push_back(mk_exp(1'b1, 100));
        start_run();
        advance_to(99);
        @(negedge clk);
        check("wd_busy_c99",  {31'd0, busy}, 1);
        check("wd_count_c99", {16'd0, cycle_count}, 99);
        advance_to(100);
        @(negedge clk);
        check("wd_busy_c100", {31'd0, busy}, 1);
        advance_to(101);
        @(negedge clk);
        check("wd_done_core_reset", {31'd0, core_reset}, 0);
        advance_to(104);
        @(negedge clk);
        check("wd_hold_count",   {16'd0, cycle_count}, 100);
        check("wd_hold_timeout", {31'd0, timeout}, 1);
        check("wd_hold_done",    {31'd0, done}, 1);
        check("req_pulses_run2", req_seen, 2);

        // Done and watchdog limit on the same cycle: normal completion wins.
        exp_q.push_back(mk_exp(1'b0, 100));
        start_run();
        @(negedge clk);
        check("rerun_done_cleared",    {31'd0, done}, 0);
        check("rerun_timeout_cleared", {31'd0, timeout}, 0);
        check("rerun_count_cleared",   {16'd0, cycle_count}, 0);
        check("rerun_core_reset",      {31'd0, core_reset}, 1);
        check("rerun_busy",            {31'd0, busy}, 1);
        advance_to(100);
        core_done = 1'b1;
        advance_to(101);
        core_done = 1'b0;

        // Back-to-back runs with start held high through the first DONE.
        exp_q.push_back(mk_exp(1'b0, 20));
        exp_q.push_back(mk_exp(1'b0, 5));
        start = 1'b1;
        cur   = -RST;
        n_rst = 0;
        for (int i = 0; i < RST + 2; i++) begin
            advance_to(cur + 1);
            @(negedge clk);
            if (core_reset === 1'b1) n_rst++;
            if (i == 0) check("b2b_done_cleared", {31'd0, done}, 0);
        end
        check("b2b_core_reset_len", n_rst, RST);
        advance_to(20);
        core_done = 1'b1;
        advance_to(21);
        core_done = 1'b0;
        cur = -RST;
        advance_to(1 - RST);
        start = 1'b0;
        @(negedge clk);
        check("b2b_second_done_cleared",  {31'd0, done}, 0);
        check("b2b_second_count_cleared", {16'd0, cycle_count}, 0);
        advance_to(5);
        core_done = 1'b1;
        advance_to(6);
        core_done = 1'b0;
        advance_to(9);
        @(negedge clk);
        check("b2b_parked_done",  {31'd0, done}, 1);
        check("b2b_parked_busy",  {31'd0, busy}, 0);
        check("b2b_parked_count", {16'd0, cycle_count}, 5);
        check("req_pulses_b2b",   req_seen, 5);

        // Reset asserted during RUN cycle 10 aborts without keeping status.
        start_run();
        advance_to(10);
        @(negedge clk);
        check("abort_count_c10", {16'd0, cycle_count}, 10);
        reset = 1'b1;
        advance_to(11);
        reset = 1'b0;
        @(negedge clk);
        check("abort_core_reset", {31'd0, core_reset}, 1);
        check("abort_done",       {31'd0, done}, 0);
        check("abort_timeout",    {31'd0, timeout}, 0);
        check("abort_count",      {16'd0, cycle_count}, 0);
        check("abort_busy",       {31'd0, busy}, 0);
        check("abort_core_req",   {31'd0, core_req}, 0);

        // A fresh run from IDLE after the abort.
        exp_q.push_back(mk_exp(1'b0, 3));
        start_run();
        advance_to(3);
        core_done = 1'b1;
        advance_to(4);
        core_done = 1'b0;
        advance_to(6);
        @(negedge clk);
        check("req_pulses_total", req_seen, 7);

        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
